// File: rtl/v810_ebi_if.sv
// V810 MAU bus interfaces: CPU-side cycle signals and the SRAM-side strobes.
// The target connects to the slave side of the CPU bus and the master side of the memory bus.

interface v810_cpu_if;
    logic [31:0] A;
    logic [31:0] D_I;
    logic [31:0] D_O;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        DAn;
    logic        MRQn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;
    logic        SZRQn;

    modport master (
        output A, D_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
        input  D_O, READYn, SZRQn
    );

    modport slave (
        input  A, D_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
        output D_O, READYn, SZRQn
    );
endinterface

interface v810_mem_if #(
    parameter int NREG = 2
);
    logic [29:0]     MEM_A;
    logic [NREG-1:0] MEM_nCE;
    logic            MEM_nWE;
    logic [3:0]      MEM_nBE;
    logic [31:0]     MEM_DI;
    logic [31:0]     MEM_DO;

    modport master (
        output MEM_A, MEM_nCE, MEM_nWE, MEM_nBE, MEM_DI,
        input  MEM_DO
    );

    modport slave (
        input  MEM_A, MEM_nCE, MEM_nWE, MEM_nBE, MEM_DI,
        output MEM_DO
    );
endinterface

// File: rtl/v810_ebi_target.sv
// V810 external-bus target: window decode, per-window wait states and 16/32-bit width,
// READYn/SZRQn generation, byte-lane steering and a sticky unmapped-access error flag.

module v810_ebi_target #(
    parameter int                 NREG     = 2,
    parameter logic [NREG*32-1:0] REG_BASE = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NREG*32-1:0] REG_MASK = {32'h8000_0000, 32'h8000_0000},
    parameter logic [NREG*4-1:0]  REG_WS   = {4'd0, 4'd0},
    parameter logic [NREG-1:0]    REG_DW16 = 2'b00,
    parameter int                 UNMAP_WS = 2
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              CE,
    v810_cpu_if.slave         cpu,
    v810_mem_if.master        mem,
    output logic              ERR,
    output logic [31:0]       ERR_ADDR
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [29:0]   r_addr;
    logic [3:0]    r_ben;
    logic          r_rw;
    logic          r_hitValid;
    logic          r_unmap;
    logic [IW-1:0] r_hit;
    logic          r_daSeen;
    logic          r_err;
    logic [31:0]   r_errAddr;

    logic          w_hit;
    logic [IW-1:0] w_hitIdx;
    logic [3:0]    w_wsLoad;
    logic          w_start;
    logic          w_ready;
    logic          w_abort;
    logic          w_dw16;
    logic          w_upper;
    logic [1:0]    w_laneBen;
    logic          w_unusedSt;

    // Scanning downwards lets the lowest-index matching window win.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((cpu.A & REG_MASK[i*32 +: 32]) == REG_BASE[i*32 +: 32]) begin
                w_hit    = 1'b1;
                w_hitIdx = IW'(i);
            end
        end
    end

    always_comb begin
        w_wsLoad = 4'(UNMAP_WS);
        if (cpu.MRQn)
            w_wsLoad = 4'd0;
        else if (w_hit)
            w_wsLoad = REG_WS[{w_hitIdx, 2'b00} +: 4];
    end

    assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && !cpu.BCYSTn;
    assign w_ready    = (r_state == S_WAIT) && (r_cnt == 4'd0) && !cpu.DAn;
    assign w_abort    = (r_state == S_WAIT) && cpu.DAn && r_daSeen;
    assign w_dw16     = r_hitValid && REG_DW16[r_hit];
    assign w_upper    = (r_ben[1:0] == 2'b11);
    assign w_laneBen  = w_upper ? r_ben[3:2] : r_ben[1:0];
    assign w_unusedSt = ^cpu.ST;

    // A start in DONE is accepted exactly like one in IDLE so back-to-back cycles lose no clock.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 30'd0;
            r_ben      <= 4'hF;
            r_rw       <= 1'b1;
            r_hitValid <= 1'b0;
            r_unmap    <= 1'b0;
            r_hit      <= '0;
            r_daSeen   <= 1'b0;
            r_err      <= 1'b0;
            r_errAddr  <= 32'd0;
        end else if (CE) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state    <= S_WAIT;
                        r_addr     <= cpu.A[31:2];
                        r_ben      <= cpu.BEn;
                        r_rw       <= cpu.RW;
                        r_hitValid <= !cpu.MRQn && w_hit;
                        r_unmap    <= !cpu.MRQn && !w_hit;
                        r_hit      <= w_hitIdx;
                        r_cnt      <= w_wsLoad;
                        r_daSeen   <= !cpu.DAn;
                        if (!cpu.MRQn && !w_hit && !r_err) begin
                            r_err     <= 1'b1;
                            r_errAddr <= cpu.A;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (w_ready) begin
                        r_state <= S_DONE;
                    end else if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != 4'd0)
                            r_cnt <= r_cnt - 4'd1;
                        if (!cpu.DAn)
                            r_daSeen <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu.READYn = !w_ready;
    assign cpu.SZRQn  = !(w_ready && w_dw16 && (r_ben[1:0] != 2'b11) && (r_ben[3:2] != 2'b11));

    // Unmapped reads float high like an empty bus; acknowledge cycles return zero.
    always_comb begin
        cpu.D_O = 32'd0;
        if (r_state == S_WAIT) begin
            if (r_hitValid)
                cpu.D_O = w_dw16 ? {mem.MEM_DO[15:0], mem.MEM_DO[15:0]} : mem.MEM_DO;
            else if (r_unmap)
                cpu.D_O = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        mem.MEM_nCE = '1;
        if ((r_state == S_WAIT) && r_hitValid)
            mem.MEM_nCE[r_hit] = 1'b0;
    end

    always_comb begin
        mem.MEM_nBE = 4'hF;
        if (r_hitValid)
            mem.MEM_nBE = w_dw16 ? {2'b11, w_laneBen} : r_ben;
    end

    always_comb begin
        mem.MEM_DI = cpu.D_I;
        if (w_dw16)
            mem.MEM_DI = {16'h0000, (w_upper ? cpu.D_I[31:16] : cpu.D_I[15:0])};
    end

    assign mem.MEM_A   = r_addr;
    assign mem.MEM_nWE = !(w_ready && !r_rw && r_hitValid);
    assign ERR         = r_err;
    assign ERR_ADDR    = r_errAddr;

endmodule

// File: tb/tb_v810_ebi_target.sv
// Directed bench for v810_ebi_target: four windows (two 32-bit WS0/WS3, one 16-bit, one WS5),
// expected data queued when a cycle is issued and popped when READYn is seen.

module tb_v810_ebi_target;

    logic        CLK;
    logic        RES;
    logic        CE;
    logic        ERR;
    logic [31:0] ERR_ADDR;

    int          nVec     = 0;
    int          nErr     = 0;
    int          weCount  = 0;
    string       tagQ[$];
    logic [31:0] valQ[$];

    v810_cpu_if                cpu ();
    v810_mem_if #(.NREG(4))    mem ();

    v810_ebi_target #(
        .NREG     (4),
        .REG_BASE ({32'h5000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000}),
        .REG_MASK ({32'hF000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000}),
        .REG_WS   ({4'd5, 4'd0, 4'd0, 4'd3}),
        .REG_DW16 (4'b0100),
        .UNMAP_WS (2)
    ) dut (
        .CLK      (CLK),
        .RES      (RES),
        .CE       (CE),
        .cpu      (cpu),
        .mem      (mem),
        .ERR      (ERR),
        .ERR_ADDR (ERR_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mem.MEM_nWE === 1'b0)
            weCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expectData(input string tag, input logic [31:0] v);
        tagQ.push_back(tag);
        valQ.push_back(v);
    endtask

    task automatic checkScoreboard(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        if (valQ.size() == 0) begin
            nVec++;
            nErr++;
            $error("[TB] FAIL scoreboard: observed %h expected nothing queued", obs);
        end else begin
            t = tagQ.pop_front();
            v = valQ.pop_front();
            checkOutput(t, obs, v);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic rw, input logic [3:0] ben,
                                 input logic mrqn, input logic [1:0] st, input logic [31:0] di);
        cpu.A      = a;
        cpu.RW     = rw;
        cpu.BEn    = ben;
        cpu.MRQn   = mrqn;
        cpu.ST     = st;
        cpu.D_I    = di;
        cpu.BCYSTn = 1'b0;
        cpu.DAn    = 1'b0;
    endtask

    // Returns the number of cycles after the BCYSTn cycle until READYn is low, or -1.
    task automatic waitReady(output int n);
        bit found;
        found = 1'b0;
        n     = -1;
        for (int i = 1; i <= 16; i++) begin
            if (!found) begin
                @(posedge CLK);
                #2;
                cpu.BCYSTn = 1'b1;
                #1;
                if (cpu.READYn === 1'b0) begin
                    n     = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic endCycle(input string tag);
        @(posedge CLK);
        #2;
        cpu.DAn = 1'b1;
        #1;
        checkOutput(tag, 32'(cpu.READYn), 32'd1);
    endtask

    initial begin
        int n;
        int we0;

        RES         = 1'b1;
        CE          = 1'b1;
        cpu.A       = 32'd0;
        cpu.D_I     = 32'd0;
        cpu.BEn     = 4'hF;
        cpu.ST      = 2'b00;
        cpu.DAn     = 1'b1;
        cpu.MRQn    = 1'b0;
        cpu.RW      = 1'b1;
        cpu.BCYSTn  = 1'b1;
        mem.MEM_DO  = 32'd0;
        #3;
        checkOutput("rstReadyn", 32'(cpu.READYn), 32'd1);
        checkOutput("rstSzrqn",  32'(cpu.SZRQn), 32'd1);
        checkOutput("rstNce",    32'(mem.MEM_nCE), 32'hF);
        checkOutput("rstNwe",    32'(mem.MEM_nWE), 32'd1);
        checkOutput("rstNbe",    32'(mem.MEM_nBE), 32'hF);
        checkOutput("rstDo",     cpu.D_O, 32'd0);
        checkOutput("rstErr",    32'(ERR), 32'd0);
        checkOutput("rstErrAddr", ERR_ADDR, 32'd0);
        tick();
        tick();
        RES = 1'b0;
        tick();

        $display("[TB] 32-bit zero-wait read in window 1");
        mem.MEM_DO = 32'hDEAD_BEEF;
        applyStimulus(32'h8000_0004, 1'b1, 4'h0, 1'b0, 2'b10, 32'd0);
        expectData("rdW1Data", 32'hDEAD_BEEF);
        waitReady(n);
        checkOutput("rdW1Lat", 32'(n), 32'd1);
        checkScoreboard(cpu.D_O);
        checkOutput("rdW1MemA", 32'(mem.MEM_A), 32'h2000_0001);
        checkOutput("rdW1Nce", 32'(mem.MEM_nCE), 32'hD);
        checkOutput("rdW1Nwe", 32'(mem.MEM_nWE), 32'd1);
        endCycle("rdW1DoneReady");
        checkOutput("rdW1DoneNce", 32'(mem.MEM_nCE), 32'hF);
        tick();

        $display("[TB] 32-bit three-wait write in window 0");
        we0 = weCount;
        applyStimulus(32'h0000_0010, 1'b0, 4'h0, 1'b0, 2'b10, 32'h1234_5678);
        expectData("wrW0Di", 32'h1234_5678);
        waitReady(n);
        checkOutput("wrW0Lat", 32'(n), 32'd4);
        checkOutput("wrW0Nwe", 32'(mem.MEM_nWE), 32'd0);
        checkScoreboard(mem.MEM_DI);
        checkOutput("wrW0Nce", 32'(mem.MEM_nCE), 32'hE);
        checkOutput("wrW0Nbe", 32'(mem.MEM_nBE), 32'h0);
        endCycle("wrW0DoneReady");
        checkOutput("wrW0DoneNwe", 32'(mem.MEM_nWE), 32'd1);
        tick();
        checkOutput("wrW0StrobeCount", 32'(weCount - we0), 32'd1);

        $display("[TB] 16-bit window: word read split into two halves");
        mem.MEM_DO = 32'h0000_1234;
        applyStimulus(32'hC000_0000, 1'b1, 4'h0, 1'b0, 2'b10, 32'd0);
        expectData("rd16LoData", 32'h1234_1234);
        waitReady(n);
        checkOutput("rd16LoLat", 32'(n), 32'd1);
        checkOutput("rd16LoSzrq", 32'(cpu.SZRQn), 32'd0);
        checkScoreboard(cpu.D_O);
        checkOutput("rd16LoNbe", 32'(mem.MEM_nBE), 32'hC);
        checkOutput("rd16LoNce", 32'(mem.MEM_nCE), 32'hB);
        endCycle("rd16LoDoneReady");
        checkOutput("rd16LoDoneSzrq", 32'(cpu.SZRQn), 32'd1);
        tick();
        mem.MEM_DO = 32'h0000_ABCD;
        applyStimulus(32'hC000_0002, 1'b1, 4'b0011, 1'b0, 2'b10, 32'd0);
        expectData("rd16HiData", 32'hABCD_ABCD);
        waitReady(n);
        checkOutput("rd16HiLat", 32'(n), 32'd1);
        checkOutput("rd16HiSzrq", 32'(cpu.SZRQn), 32'd1);
        checkScoreboard(cpu.D_O);
        checkOutput("rd16HiNbe", 32'(mem.MEM_nBE), 32'hC);
        endCycle("rd16HiDoneReady");
        tick();

        $display("[TB] 16-bit window: halfword writes");
        applyStimulus(32'hC000_0002, 1'b0, 4'b0011, 1'b0, 2'b10, 32'h5555_AAAA);
        expectData("wr16HiDi", 32'h0000_5555);
        waitReady(n);
        checkScoreboard(mem.MEM_DI);
        checkOutput("wr16HiNwe", 32'(mem.MEM_nWE), 32'd0);
        checkOutput("wr16HiNbe", 32'(mem.MEM_nBE), 32'hC);
        checkOutput("wr16HiSzrq", 32'(cpu.SZRQn), 32'd1);
        endCycle("wr16HiDoneReady");
        tick();
        applyStimulus(32'hC000_0000, 1'b0, 4'b1110, 1'b0, 2'b10, 32'h1111_2222);
        expectData("wr16LoDi", 32'h0000_2222);
        waitReady(n);
        checkScoreboard(mem.MEM_DI);
        checkOutput("wr16LoNbe", 32'(mem.MEM_nBE), 32'hE);
        checkOutput("wr16LoSzrq", 32'(cpu.SZRQn), 32'd1);
        endCycle("wr16LoDoneReady");
        tick();

        $display("[TB] unmapped accesses");
        mem.MEM_DO = 32'd0;
        applyStimulus(32'h4000_0000, 1'b1, 4'h0, 1'b0, 2'b10, 32'd0);
        expectData("unmapRdData", 32'hFFFF_FFFF);
        waitReady(n);
        checkOutput("unmapRdLat", 32'(n), 32'd3);
        checkScoreboard(cpu.D_O);
        checkOutput("unmapRdNce", 32'(mem.MEM_nCE), 32'hF);
        checkOutput("unmapErr", 32'(ERR), 32'd1);
        checkOutput("unmapErrAddr", ERR_ADDR, 32'h4000_0000);
        endCycle("unmapRdDoneReady");
        tick();
        we0 = weCount;
        applyStimulus(32'h6000_0008, 1'b0, 4'h0, 1'b0, 2'b10, 32'hAAAA_5555);
        waitReady(n);
        checkOutput("unmapWrLat", 32'(n), 32'd3);
        checkOutput("unmapWrNwe", 32'(mem.MEM_nWE), 32'd1);
        endCycle("unmapWrDoneReady");
        tick();
        checkOutput("unmapWrErrAddr", ERR_ADDR, 32'h4000_0000);
        checkOutput("unmapWrStrobeCount", 32'(weCount - we0), 32'd0);

        $display("[TB] acknowledge cycle followed by back-to-back read");
        mem.MEM_DO = 32'h1111_1111;
        applyStimulus(32'h8000_0000, 1'b1, 4'h0, 1'b1, 2'b01, 32'd0);
        expectData("ackData", 32'd0);
        waitReady(n);
        checkOutput("ackLat", 32'(n), 32'd1);
        checkScoreboard(cpu.D_O);
        checkOutput("ackNce", 32'(mem.MEM_nCE), 32'hF);
        tick();
        mem.MEM_DO = 32'hCAFE_F00D;
        applyStimulus(32'h8000_0008, 1'b1, 4'h0, 1'b0, 2'b10, 32'd0);
        #1;
        checkOutput("b2bDoneReady", 32'(cpu.READYn), 32'd1);
        expectData("b2bData", 32'hCAFE_F00D);
        waitReady(n);
        checkOutput("b2bLat", 32'(n), 32'd1);
        checkScoreboard(cpu.D_O);
        checkOutput("b2bErr", 32'(ERR), 32'd1);
        checkOutput("b2bErrAddr", ERR_ADDR, 32'h4000_0000);
        endCycle("b2bDoneReadyEnd");
        tick();

        $display("[TB] clock enable low freezes the wait counter");
        mem.MEM_DO = 32'h0BAD_F00D;
        applyStimulus(32'h0000_0020, 1'b1, 4'h0, 1'b0, 2'b10, 32'd0);
        expectData("ceHoldData", 32'h0BAD_F00D);
        tick();
        cpu.BCYSTn = 1'b1;
        CE = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            checkOutput($sformatf("ceHoldReady%0d", k), 32'(cpu.READYn), 32'd1);
        end
        checkOutput("ceHoldNce", 32'(mem.MEM_nCE), 32'hE);
        CE = 1'b1;
        waitReady(n);
        checkOutput("ceHoldLat", 32'(n), 32'd3);
        checkScoreboard(cpu.D_O);
        endCycle("ceHoldDoneReady");
        tick();

        $display("[TB] data strobe withdrawn mid-cycle");
        we0 = weCount;
        applyStimulus(32'h0000_0030, 1'b0, 4'h0, 1'b0, 2'b10, 32'hFEED_FACE);
        tick();
        cpu.BCYSTn = 1'b1;
        cpu.DAn    = 1'b1;
        tick();
        #1;
        checkOutput("abortReady", 32'(cpu.READYn), 32'd1);
        checkOutput("abortNce", 32'(mem.MEM_nCE), 32'hF);
        tick();
        checkOutput("abortStrobeCount", 32'(weCount - we0), 32'd0);

        $display("[TB] reset during a five-wait write");
        we0 = weCount;
        applyStimulus(32'h5000_0000, 1'b0, 4'h0, 1'b0, 2'b10, 32'h0F0F_0F0F);
        tick();
        cpu.BCYSTn = 1'b1;
        tick();
        #1;
        checkOutput("rstMidNceBefore", 32'(mem.MEM_nCE), 32'h7);
        RES = 1'b1;
        #1;
        checkOutput("rstMidReady", 32'(cpu.READYn), 32'd1);
        checkOutput("rstMidNwe", 32'(mem.MEM_nWE), 32'd1);
        checkOutput("rstMidNce", 32'(mem.MEM_nCE), 32'hF);
        checkOutput("rstMidErr", 32'(ERR), 32'd0);
        checkOutput("rstMidErrAddr", ERR_ADDR, 32'd0);
        tick();
        tick();
        cpu.DAn = 1'b1;
        RES = 1'b0;
        tick();
        checkOutput("rstMidStrobeCount", 32'(weCount - we0), 32'd0);
        mem.MEM_DO = 32'h1357_9BDF;
        applyStimulus(32'h8000_000C, 1'b1, 4'h0, 1'b0, 2'b10, 32'd0);
        expectData("postRstData", 32'h1357_9BDF);
        waitReady(n);
        checkOutput("postRstLat", 32'(n), 32'd1);
        checkScoreboard(cpu.D_O);
        endCycle("postRstDoneReady");
        tick();

        checkOutput("sbEmpty", 32'(valQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/v810_ebi_target.md
Name: v810_ebi_target

Overview:
Parametrised external-bus target for the V810 MAU bus, replacing hand-wired wait-state and width models in front of RAMs. Decodes up to NREG address windows. Each window has its own wait-state count and 32/16-bit width. Generates READYn and SZRQn, steers byte lanes, and strobes one SRAM per window. Adds unmapped-access and non-memory-cycle handling with a sticky error flag.

Parameters:
NREG, 2, number of address windows (1..8)
REG_BASE, {32'h8000_0000, 32'h0000_0000}, packed NREG*32 window base addresses (window 0 in LSBs)
REG_MASK, {32'h8000_0000, 32'h8000_0000}, packed NREG*32 decode masks; hit when (A & MASK) == BASE
REG_WS, {4'd0, 4'd0}, packed NREG*4 wait states per window (0..15)
REG_DW16, 2'b00, per-window flag: 1 = 16-bit device, 0 = 32-bit
UNMAP_WS, 2, wait states before an unmapped access is terminated

Ports:
CLK  in  1  clock
RES  in  1  asynchronous reset, active-high
CE  in  1  clock enable; all state advances only when CE=1
A  in  32  CPU address
D_I  in  32  CPU write data
D_O  out  32  read data to CPU
BEn  in  4  byte enables, active-low
ST  in  2  bus status
DAn  in  1  data strobe, active-low
MRQn  in  1  memory request, active-low; high = I/O or acknowledge cycle
RW  in  1  1 = read, 0 = write
BCYSTn  in  1  bus cycle start, active-low
READYn  out  1  cycle termination, active-low
SZRQn  out  1  16-bit size request, active-low
MEM_A  out  30  word address to SRAM (A[31:2] latched)
MEM_nCE  out  NREG  per-window chip enable, active-low
MEM_nWE  out  1  write strobe, active-low
MEM_nBE  out  4  lane enables to SRAM, active-low
MEM_DI  out  32  write data to SRAM
MEM_DO  in  32  read data from SRAM; combinational read
ERR  out  1  sticky unmapped-access flag
ERR_ADDR  out  32  address of first unmapped access

Behaviour:
- Reset (async, RES=1): state IDLE; READYn=1, SZRQn=1, MEM_nCE all 1, MEM_nWE=1, MEM_nBE=4'hF, D_O=0, ERR=0, ERR_ADDR=0.
- States: IDLE, WAIT, DONE.
- IDLE: on CE edge with BCYSTn=0, latch A, BEn, RW and MRQn. Decode window: lowest-index hit wins. Load counter with REG_WS[hit]. If no hit, load UNMAP_WS. If MRQn=1, load 0 and select no window. Go to WAIT.
- WAIT: counter decrements each CE cycle while >0. When counter==0 and DAn=0, assert READYn=0 combinationally that cycle and go to DONE.
- Timing: with 0 wait states, READYn is low in the first cycle after BCYSTn (T2).
- Memory strobes: MEM_nCE[hit]=0 for the whole WAIT state. MEM_nWE=0 only in the READYn-low cycle of a write. MEM_A and MEM_nBE are held from the latched values.
- DONE: READYn=1 next cycle. Return to IDLE. BCYSTn=0 in DONE is handled as in IDLE (back-to-back cycles).
- 32-bit window: D_O=MEM_DO. MEM_DI=D_I. MEM_nBE=latched BEn.
- 16-bit window:
  - Device occupies lanes [15:0]. Halfword select is the upper half when BEn[1:0]==2'b11, otherwise the lower half.
  - Read: the halfword is replicated on D_O[31:16] and D_O[15:0].
  - Write: the selected CPU half is routed to MEM_DI[15:0].
  - MEM_nBE: {2'b11, selected BEn pair}.
  - SZRQn=0 together with READYn when both BEn halves have any lane enabled. The CPU then reissues for the upper half; the block treats that as a new cycle.
- Unmapped read: D_O=32'hFFFF_FFFF, no strobe. Unmapped write is discarded.
- Unmapped access (read or write): the first one sets ERR=1 and captures ERR_ADDR. ERR stays set until reset.
- MRQn=1 cycles (I/O or halt acknowledge): READYn in T2, no strobe, D_O=0, ERR unaffected.
- CE=0: all registers hold; combinational outputs keep their last state-derived values.
- DAn returning high before READYn: abort to IDLE, no write strobe.
- RES mid-cycle: immediate IDLE. No READYn or MEM_nWE glitch low after RES rises.

Test Plan:
- Window1 (base 8000_0000, WS=0, 32-bit), read A=8000_0004 with MEM_DO=DEADBEEF -> READYn low in T2, D_O=DEADBEEF, MEM_A=0x20000001, MEM_nCE=2'b01.
- Window0 WS=3, write D_I=12345678, BEn=0 -> READYn low exactly 4 cycles after BCYSTn, MEM_nWE low one cycle, MEM_DI=12345678.
- Window0 REG_DW16=1, word read BEn=0 -> first cycle: READYn=0 and SZRQn=0 together. Reissue with BEn=4'b0011 and MEM_DO[15:0]=ABCD -> D_O=ABCD_ABCD, SZRQn=1, MEM_nBE=4'b1100.
- Unmapped access A=4000_0000 with masks restricted to A[31:30] -> READYn after 2 waits, D_O=FFFF_FFFF, ERR=1, ERR_ADDR=4000_0000. A second unmapped access leaves ERR_ADDR unchanged.
- MRQn=1, ST=2'b01 acknowledge cycle -> READYn low in T2, all MEM_nCE high. Back-to-back BCYSTn in DONE is served without an idle cycle.
- RES asserted during WAIT of a WS=5 write -> READYn=1 and MEM_nWE=1 immediately, no memory write. After release, the next access is normal.
